// File: rtl/tlp_lookahead_buffer.sv
// TLP receive buffer: decodes the SOP header into a descriptor that is queued next to the packet's beats,
// so the dispatcher sees type/len/BAR/function before the first beat; cut-through or store-and-forward release.
module tlp_lookahead_buffer #(
  parameter int pWIDTH        = 64,
  parameter int pDEPTH        = 64,
  parameter int pPKTS         = 8,
  parameter int pSTORE_FWD    = 1,
  parameter int pDROP_ERR     = 1,
  parameter int pREADY_MARGIN = 4
) (
  input  logic                      i_Clk,
  input  logic                      i_ARstN,
  input  logic                      i_InRxDv,
  input  logic                      i_InRxSop,
  input  logic                      i_InRxEop,
  input  logic                      i_InRxErr,
  input  logic                      i_InRxEmpty,
  input  logic [pWIDTH-1:0]         iv_InRxData,
  input  logic [7:0]                i8_BarHit,
  input  logic [2:0]                i3_Function,
  output logic                      o_InRxReady,
  output logic                      o_OutRxDv,
  output logic                      o_OutRxSop,
  output logic                      o_OutRxEop,
  output logic                      o_OutRxErr,
  output logic                      o_OutRxEmpty,
  output logic [pWIDTH-1:0]         ov_OutRxData,
  input  logic                      i_OutRxReady,
  output logic                      o_NxtPktValid,
  output logic                      o_NxtPktMemWr,
  output logic                      o_NxtPktMemRd,
  output logic                      o_NxtPktIOWr,
  output logic                      o_NxtPktIORd,
  output logic                      o_NxtPktCmplD,
  output logic                      o_NxtPktCmpl,
  output logic                      o_NxtPktOthers,
  output logic [9:0]                o10_NxtPktPayldLen,
  output logic [7:0]                o8_NxtPktBarHit,
  output logic [2:0]                o3_NxtPktFuncHit,
  output logic [$clog2(pPKTS):0]    ov_PktCnt,
  output logic                      o_DropPulse,
  output logic                      o_OvfPulse
);
  localparam int AW = $clog2(pDEPTH);
  localparam int PW = $clog2(pPKTS);
  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_P   = (AW+1)'(pDEPTH);
  localparam logic [AW:0] MARGIN_P  = (AW+1)'(pREADY_MARGIN);
  localparam logic [PW:0] PKT_ONE   = (PW+1)'(1);
  localparam logic [PW:0] PKTS_P    = (PW+1)'(pPKTS);
  localparam logic [PW:0] PKTS_HI   = (PW+1)'(pPKTS - 1);

  typedef struct packed {
    logic              empty;
    logic              err;
    logic              sop;
    logic              eop;
    logic [pWIDTH-1:0] dat;
  } beat_t;

  typedef struct packed {
    logic       mem_wr;
    logic       mem_rd;
    logic       io_wr;
    logic       io_rd;
    logic       cmpl_d;
    logic       cmpl;
    logic       others;
    logic [9:0] len;
    logic [7:0] bar;
    logic [2:0] func;
  } desc_t;

  beat_t       beat_mem [pDEPTH];
  desc_t       desc_mem [pPKTS];

  logic [AW:0] wptr_q, wptr_d, cptr_q, cptr_d, rptr_q, rptr_d, wbase, occ_d;
  logic [PW:0] dwr_q, dwr_d, drd_q, drd_d, pkt_cnt, pkt_cnt_d;
  logic        pkt_open_q, pkt_open_d, err_seen_q, err_seen_d, discard_q, discard_d;
  logic        drop_pulse_q, drop_pulse_d, ovf_pulse_q, ovf_pulse_d, in_rdy_q, in_rdy_d;
  desc_t       desc_hold_q, desc_hold_d, in_desc, desc_push_dat, desc_head;
  logic [4:0]  hdr_type;
  beat_t       beat_wdat, rd_beat;
  logic        beat_we, desc_push, desc_pop, desc_push_ok, desc_pop_ok;
  logic        full_q, err_pkt, out_dv, nxt_vld;
  logic [AW-1:0] beat_waddr;

  // Header decode of the current input beat; only meaningful on SOP.
  always_comb begin
    hdr_type        = iv_InRxData[28:24];
    in_desc         = '0;
    in_desc.mem_wr  = (hdr_type == 5'b00000) &&  iv_InRxData[30];
    in_desc.mem_rd  = (hdr_type == 5'b00000) && !iv_InRxData[30];
    in_desc.io_wr   = (hdr_type == 5'b00010) &&  iv_InRxData[30];
    in_desc.io_rd   = (hdr_type == 5'b00010) && !iv_InRxData[30];
    in_desc.cmpl_d  = (hdr_type == 5'b01010) &&  iv_InRxData[30];
    in_desc.cmpl    = (hdr_type == 5'b01010) && !iv_InRxData[30];
    in_desc.others  = (hdr_type != 5'b00000) && (hdr_type != 5'b00010) && (hdr_type != 5'b01010);
    in_desc.len     = iv_InRxData[9:0];
    in_desc.bar     = i8_BarHit;
    in_desc.func    = i3_Function;
    beat_wdat.empty = i_InRxEmpty;
    beat_wdat.err   = i_InRxErr;
    beat_wdat.sop   = i_InRxSop;
    beat_wdat.eop   = i_InRxEop;
    beat_wdat.dat   = iv_InRxData;
  end

  // Write side: a new SOP always restarts from the committed pointer, which discards any open packet.
  always_comb begin
    wptr_d        = wptr_q;
    cptr_d        = cptr_q;
    pkt_open_d    = pkt_open_q;
    err_seen_d    = err_seen_q;
    discard_d     = discard_q;
    desc_hold_d   = desc_hold_q;
    drop_pulse_d  = 1'b0;
    ovf_pulse_d   = 1'b0;
    beat_we       = 1'b0;
    desc_push     = 1'b0;
    desc_push_dat = desc_hold_q;
    full_q        = (wptr_q - rptr_q) == DEPTH_P;
    wbase         = i_InRxSop ? cptr_q : wptr_q;
    err_pkt       = (i_InRxSop ? 1'b0 : err_seen_q) | i_InRxErr;
    beat_waddr    = wptr_q[AW-1:0];
    if (i_InRxDv) begin
      if (pSTORE_FWD == 0) begin
        if (full_q) begin
          ovf_pulse_d = 1'b1;
        end else begin
          beat_we   = 1'b1;
          wptr_d    = wptr_q + PTR_ONE;
          desc_push = i_InRxSop;
          desc_push_dat = in_desc;
        end
        cptr_d = wptr_d;
      end else begin
        if (i_InRxSop) begin
          discard_d    = 1'b0;
          drop_pulse_d = pkt_open_q;
        end
        if (i_InRxSop || pkt_open_q) begin
          beat_waddr = wbase[AW-1:0];
          if ((wbase - rptr_q) == DEPTH_P) begin
            ovf_pulse_d  = 1'b1;
            drop_pulse_d = 1'b1;
            wptr_d       = cptr_q;
            pkt_open_d   = 1'b0;
            err_seen_d   = 1'b0;
            discard_d    = !i_InRxEop;
          end else begin
            beat_we = 1'b1;
            wptr_d  = wbase + PTR_ONE;
            if (i_InRxSop) desc_hold_d = in_desc;
            if (i_InRxEop) begin
              pkt_open_d = 1'b0;
              err_seen_d = 1'b0;
              if ((pDROP_ERR != 0) && err_pkt) begin
                drop_pulse_d = 1'b1;
                wptr_d       = cptr_q;
              end else begin
                cptr_d        = wbase + PTR_ONE;
                desc_push     = 1'b1;
                desc_push_dat = i_InRxSop ? in_desc : desc_hold_q;
              end
            end else begin
              pkt_open_d = 1'b1;
              err_seen_d = err_pkt;
            end
          end
        end else if (discard_q && i_InRxEop) begin
          discard_d = 1'b0;
        end
      end
    end
  end

  // Read side, descriptor queue and registered ready (computed from next-state occupancy).
  always_comb begin
    rd_beat     = beat_mem[rptr_q[AW-1:0]];
    out_dv      = (rptr_q != cptr_q) && i_OutRxReady;
    rptr_d      = out_dv ? rptr_q + PTR_ONE : rptr_q;
    desc_pop    = out_dv && rd_beat.eop;
    pkt_cnt     = dwr_q - drd_q;
    nxt_vld     = pkt_cnt != '0;
    desc_head   = desc_mem[drd_q[PW-1:0]];
    desc_push_ok = desc_push && (pkt_cnt != PKTS_P);
    desc_pop_ok  = desc_pop && nxt_vld;
    dwr_d       = desc_push_ok ? dwr_q + PKT_ONE : dwr_q;
    drd_d       = desc_pop_ok ? drd_q + PKT_ONE : drd_q;
    pkt_cnt_d   = dwr_d - drd_d;
    occ_d       = wptr_d - rptr_d;
    in_rdy_d    = ((DEPTH_P - occ_d) > MARGIN_P) && (pkt_cnt_d < PKTS_HI);
  end

  always_ff @(posedge i_Clk or negedge i_ARstN) begin
    if (!i_ARstN) begin
      wptr_q       <= '0;
      cptr_q       <= '0;
      rptr_q       <= '0;
      dwr_q        <= '0;
      drd_q        <= '0;
      pkt_open_q   <= 1'b0;
      err_seen_q   <= 1'b0;
      discard_q    <= 1'b0;
      desc_hold_q  <= '0;
      drop_pulse_q <= 1'b0;
      ovf_pulse_q  <= 1'b0;
      in_rdy_q     <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      cptr_q       <= cptr_d;
      rptr_q       <= rptr_d;
      dwr_q        <= dwr_d;
      drd_q        <= drd_d;
      pkt_open_q   <= pkt_open_d;
      err_seen_q   <= err_seen_d;
      discard_q    <= discard_d;
      desc_hold_q  <= desc_hold_d;
      drop_pulse_q <= drop_pulse_d;
      ovf_pulse_q  <= ovf_pulse_d;
      in_rdy_q     <= in_rdy_d;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (beat_we)      beat_mem[beat_waddr]        <= beat_wdat;
    if (desc_push_ok) desc_mem[dwr_q[PW-1:0]]     <= desc_push_dat;
  end

  // Storage is not reset, so every output is gated by its valid.
  assign o_InRxReady        = in_rdy_q;
  assign o_OutRxDv          = out_dv;
  assign o_OutRxSop         = out_dv & rd_beat.sop;
  assign o_OutRxEop         = out_dv & rd_beat.eop;
  assign o_OutRxErr         = out_dv & rd_beat.err;
  assign o_OutRxEmpty       = out_dv & rd_beat.empty;
  assign ov_OutRxData       = out_dv ? rd_beat.dat : '0;
  assign o_NxtPktValid      = nxt_vld;
  assign o_NxtPktMemWr      = nxt_vld & desc_head.mem_wr;
  assign o_NxtPktMemRd      = nxt_vld & desc_head.mem_rd;
  assign o_NxtPktIOWr       = nxt_vld & desc_head.io_wr;
  assign o_NxtPktIORd       = nxt_vld & desc_head.io_rd;
  assign o_NxtPktCmplD      = nxt_vld & desc_head.cmpl_d;
  assign o_NxtPktCmpl       = nxt_vld & desc_head.cmpl;
  assign o_NxtPktOthers     = nxt_vld & desc_head.others;
  assign o10_NxtPktPayldLen = nxt_vld ? desc_head.len : '0;
  assign o8_NxtPktBarHit    = nxt_vld ? desc_head.bar : '0;
  assign o3_NxtPktFuncHit   = nxt_vld ? desc_head.func : '0;
  assign ov_PktCnt          = pkt_cnt;
  assign o_DropPulse        = drop_pulse_q;
  assign o_OvfPulse         = ovf_pulse_q;

endmodule

// File: tb/tb_tlp_lookahead_buffer.sv
// Directed bench: a cut-through instance (CT) and a store-and-forward instance (SF), both 16 beats deep.
module tb_tlp_lookahead_buffer;
  localparam int CT = 0;
  localparam int SF = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, sel_ct, in_dv, in_sop, in_eop, in_err, in_empty;
  logic [63:0] in_dat;
  logic [7:0]  in_bar;
  logic [2:0]  in_fn;
  logic        ct_dv, sf_dv;
  logic        ordy [2];
  logic        rdy [2], dv [2], sop [2], eop [2], err [2], emp [2];
  logic [63:0] odat [2];
  logic        nvld [2], mwr [2], mrd [2], iowr [2], iord [2], cpld [2], cpl [2], oth [2];
  logic [9:0]  len [2];
  logic [7:0]  bar [2];
  logic [2:0]  fn [2];
  logic        drop [2], ovf [2];
  logic [2:0]  c_pcnt;
  logic [3:0]  s_pcnt;

  int nvec = 0;
  int nerr = 0;

  assign ct_dv = in_dv & sel_ct;
  assign sf_dv = in_dv & ~sel_ct;

  tlp_lookahead_buffer #(.pWIDTH(64), .pDEPTH(16), .pPKTS(4), .pSTORE_FWD(0), .pDROP_ERR(0), .pREADY_MARGIN(4)) u_ct (
    .i_Clk(clk), .i_ARstN(rst_n), .i_InRxDv(ct_dv), .i_InRxSop(in_sop), .i_InRxEop(in_eop),
    .i_InRxErr(in_err), .i_InRxEmpty(in_empty), .iv_InRxData(in_dat), .i8_BarHit(in_bar),
    .i3_Function(in_fn), .o_InRxReady(rdy[CT]), .o_OutRxDv(dv[CT]), .o_OutRxSop(sop[CT]),
    .o_OutRxEop(eop[CT]), .o_OutRxErr(err[CT]), .o_OutRxEmpty(emp[CT]), .ov_OutRxData(odat[CT]),
    .i_OutRxReady(ordy[CT]), .o_NxtPktValid(nvld[CT]), .o_NxtPktMemWr(mwr[CT]), .o_NxtPktMemRd(mrd[CT]),
    .o_NxtPktIOWr(iowr[CT]), .o_NxtPktIORd(iord[CT]), .o_NxtPktCmplD(cpld[CT]), .o_NxtPktCmpl(cpl[CT]),
    .o_NxtPktOthers(oth[CT]), .o10_NxtPktPayldLen(len[CT]), .o8_NxtPktBarHit(bar[CT]),
    .o3_NxtPktFuncHit(fn[CT]), .ov_PktCnt(c_pcnt), .o_DropPulse(drop[CT]), .o_OvfPulse(ovf[CT])
  );

  tlp_lookahead_buffer #(.pWIDTH(64), .pDEPTH(16), .pPKTS(8), .pSTORE_FWD(1), .pDROP_ERR(1), .pREADY_MARGIN(4)) u_sf (
    .i_Clk(clk), .i_ARstN(rst_n), .i_InRxDv(sf_dv), .i_InRxSop(in_sop), .i_InRxEop(in_eop),
    .i_InRxErr(in_err), .i_InRxEmpty(in_empty), .iv_InRxData(in_dat), .i8_BarHit(in_bar),
    .i3_Function(in_fn), .o_InRxReady(rdy[SF]), .o_OutRxDv(dv[SF]), .o_OutRxSop(sop[SF]),
    .o_OutRxEop(eop[SF]), .o_OutRxErr(err[SF]), .o_OutRxEmpty(emp[SF]), .ov_OutRxData(odat[SF]),
    .i_OutRxReady(ordy[SF]), .o_NxtPktValid(nvld[SF]), .o_NxtPktMemWr(mwr[SF]), .o_NxtPktMemRd(mrd[SF]),
    .o_NxtPktIOWr(iowr[SF]), .o_NxtPktIORd(iord[SF]), .o_NxtPktCmplD(cpld[SF]), .o_NxtPktCmpl(cpl[SF]),
    .o_NxtPktOthers(oth[SF]), .o10_NxtPktPayldLen(len[SF]), .o8_NxtPktBarHit(bar[SF]),
    .o3_NxtPktFuncHit(fn[SF]), .ov_PktCnt(s_pcnt), .o_DropPulse(drop[SF]), .o_OvfPulse(ovf[SF])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    in_dv = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_err = 1'b0; in_empty = 1'b0;
    in_dat = '0; in_bar = '0; in_fn = '0;
  endtask

  task automatic idle();
    quiet();
    tick();
  endtask

  task automatic beat(input logic s, input logic e, input logic er, input logic [63:0] d,
                      input logic [7:0] b, input logic [2:0] f);
    in_dv = 1'b1; in_sop = s; in_eop = e; in_err = er; in_dat = d; in_bar = b; in_fn = f;
    tick();
  endtask

  function automatic logic [63:0] pat(input int i);
    logic [63:0] p;
    p = {32'hC3C3_0000 + 32'(i), 32'h5A5A_0000 + 32'(i)};
    if (i == 0) p[31:0] = 32'h0A00_0000;
    return p;
  endfunction

  initial begin
    rst_n = 1'b0; sel_ct = 1'b1; ordy[CT] = 1'b1; ordy[SF] = 1'b1;
    quiet();
    tick(); tick();
    chk("rst_ct_ready", rdy[CT], 0);
    chk("rst_sf_ready", rdy[SF], 0);
    chk("rst_ct_dv", dv[CT], 0);
    chk("rst_sf_nxtvalid", nvld[SF], 0);
    chk("rst_ct_pktcnt", c_pcnt, 0);
    chk("rst_sf_drop", drop[SF], 0);
    rst_n = 1'b1;
    tick();
    chk("rel_ct_ready", rdy[CT], 1);
    chk("rel_sf_ready", rdy[SF], 1);

    // Cut-through 3-beat MemWr
    beat(1, 0, 0, 64'hAAAA_0000_4000_0004, 8'h01, 3'd2);
    chk("ct_b0_dv", dv[CT], 1);
    chk("ct_b0_sop", sop[CT], 1);
    chk("ct_b0_dat", odat[CT], 64'hAAAA_0000_4000_0004);
    chk("ct_desc_valid", nvld[CT], 1);
    chk("ct_desc_memwr", mwr[CT], 1);
    chk("ct_desc_memrd", mrd[CT], 0);
    chk("ct_desc_len", len[CT], 4);
    chk("ct_desc_bar", bar[CT], 8'h01);
    chk("ct_desc_func", fn[CT], 2);
    chk("ct_pktcnt1", c_pcnt, 1);
    beat(0, 0, 1, 64'h1111, 8'h00, 3'd0);
    chk("ct_b1_dat", odat[CT], 64'h1111);
    chk("ct_b1_sop", sop[CT], 0);
    chk("ct_b1_err", err[CT], 1);
    in_empty = 1'b1;
    beat(0, 1, 0, 64'h2222, 8'h00, 3'd0);
    chk("ct_b2_dat", odat[CT], 64'h2222);
    chk("ct_b2_eop", eop[CT], 1);
    chk("ct_b2_empty", emp[CT], 1);
    idle();
    chk("ct_done_cnt", c_pcnt, 0);
    chk("ct_done_valid", nvld[CT], 0);
    chk("ct_done_dv", dv[CT], 0);

    // Store-and-forward 4-beat CmplD
    sel_ct = 1'b0;
    beat(1, 0, 0, 64'h0000_0000_4A00_0002, 8'h04, 3'd1);
    chk("sf_hold0", dv[SF], 0);
    beat(0, 0, 0, 64'h1, 8'h00, 3'd0);
    chk("sf_hold1", dv[SF], 0);
    beat(0, 0, 0, 64'h2, 8'h00, 3'd0);
    chk("sf_hold2", dv[SF], 0);
    chk("sf_hold_cnt", s_pcnt, 0);
    beat(0, 1, 0, 64'h3, 8'h00, 3'd0);
    chk("sf_b0_dv", dv[SF], 1);
    chk("sf_b0_sop", sop[SF], 1);
    chk("sf_b0_dat", odat[SF], 64'h4A00_0002);
    chk("sf_b0_err", err[SF], 0);
    chk("sf_b0_empty", emp[SF], 0);
    chk("sf_desc_cmpld", cpld[SF], 1);
    chk("sf_desc_len", len[SF], 2);
    chk("sf_desc_bar", bar[SF], 8'h04);
    chk("sf_desc_func", fn[SF], 1);
    chk("sf_cnt1", s_pcnt, 1);
    idle();
    chk("sf_b1_dat", odat[SF], 64'h1);
    idle();
    chk("sf_b2_dat", odat[SF], 64'h2);
    idle();
    chk("sf_b3_dat", odat[SF], 64'h3);
    chk("sf_b3_eop", eop[SF], 1);
    idle();
    chk("sf_done_dv", dv[SF], 0);
    chk("sf_done_cnt", s_pcnt, 0);

    // Error drop followed by a clean MemRd
    beat(1, 0, 0, 64'h4000_0001, 8'h01, 3'd0);
    beat(0, 0, 1, 64'hE1, 8'h00, 3'd0);
    beat(0, 1, 0, 64'hE2, 8'h00, 3'd0);
    chk("drop_pulse", drop[SF], 1);
    chk("drop_no_ovf", ovf[SF], 0);
    chk("drop_dv", dv[SF], 0);
    chk("drop_cnt", s_pcnt, 0);
    beat(1, 0, 0, 64'h0000_0003, 8'h08, 3'd3);
    chk("drop_pulse_once", drop[SF], 0);
    beat(0, 1, 0, 64'h5555, 8'h00, 3'd0);
    chk("mrd_b0_dat", odat[SF], 64'h3);
    chk("mrd_desc", mrd[SF], 1);
    chk("mrd_not_memwr", mwr[SF], 0);
    chk("mrd_len", len[SF], 3);
    chk("mrd_cnt_peak", s_pcnt, 1);
    idle();
    chk("mrd_b1_dat", odat[SF], 64'h5555);
    idle();
    chk("mrd_done_cnt", s_pcnt, 0);

    // 20-beat packet into a 16-deep buffer with the sink stalled
    ordy[SF] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      beat(i == 1, i == 20, 0, (i == 1) ? 64'h4000_0010 : 64'(i), (i == 1) ? 8'h02 : 8'h00, 3'd0);
      if (i == 11) chk("ovf_ready_free5", rdy[SF], 1);
      if (i == 12) chk("ovf_ready_free4", rdy[SF], 0);
      if (i == 17) begin
        chk("ovf_pulse", ovf[SF], 1);
        chk("ovf_drop_pulse", drop[SF], 1);
        chk("ovf_rollback_ready", rdy[SF], 1);
      end
      if (i == 18) begin
        chk("ovf_pulse_clear", ovf[SF], 0);
        chk("ovf_drop_clear", drop[SF], 0);
      end
    end
    ordy[SF] = 1'b1;
    idle();
    chk("ovf_nothing_out", dv[SF], 0);
    chk("ovf_cnt", s_pcnt, 0);

    // Fill descriptor queue with single-beat packets on the cut-through side
    sel_ct = 1'b1; ordy[CT] = 1'b0;
    beat(1, 1, 0, 64'h4200_0001, 8'h01, 3'd0);
    chk("fill1_iowr", iowr[CT], 1);
    beat(1, 1, 0, 64'h0200_0001, 8'h02, 3'd0);
    chk("fill2_ready", rdy[CT], 1);
    beat(1, 1, 0, 64'h0400_0001, 8'h04, 3'd0);
    chk("fill3_ready", rdy[CT], 0);
    chk("fill3_cnt", c_pcnt, 3);
    quiet();
    ordy[CT] = 1'b1;
    #1;
    chk("pop_dv", dv[CT], 1);
    chk("pop_sop", sop[CT], 1);
    chk("pop_eop", eop[CT], 1);
    chk("pop_dat", odat[CT], 64'h4200_0001);
    tick();
    chk("pop_ready", rdy[CT], 1);
    chk("pop_cnt", c_pcnt, 2);
    chk("pop_iord", iord[CT], 1);
    tick();
    chk("pop_others", oth[CT], 1);
    chk("pop_no_ovf", ovf[CT], 0);
    tick();
    chk("pop_empty_cnt", c_pcnt, 0);

    // 48-beat stream across several pointer wraps
    for (int i = 0; i < 48; i++) begin
      beat(i == 0, i == 47, 0, pat(i), 8'h00, 3'd0);
      chk("wrap_dat", odat[CT], pat(i));
      if (i == 0) chk("wrap_cmpl", cpl[CT], 1);
    end
    idle();
    chk("wrap_done_cnt", c_pcnt, 0);
    chk("wrap_done_dv", dv[CT], 0);

    // Reset in the middle of a packet
    sel_ct = 1'b0; ordy[SF] = 1'b0;
    beat(1, 0, 0, 64'h4000_0002, 8'h10, 3'd5);
    beat(0, 1, 0, 64'hBEEF, 8'h00, 3'd0);
    chk("mid_cnt", s_pcnt, 1);
    beat(1, 0, 0, 64'h4000_0001, 8'h10, 3'd5);
    quiet();
    ordy[SF] = 1'b1;
    #1;
    chk("mid_dv", dv[SF], 1);
    chk("mid_dat", odat[SF], 64'h4000_0002);
    rst_n = 1'b0;
    #1;
    chk("arst_dv", dv[SF], 0);
    chk("arst_valid", nvld[SF], 0);
    chk("arst_cnt", s_pcnt, 0);
    chk("arst_ready", rdy[SF], 0);
    chk("arst_dat", odat[SF], 0);
    chk("arst_len", len[SF], 0);
    chk("arst_ct_ready", rdy[CT], 0);
    rst_n = 1'b1;
    idle();
    chk("arel_ready", rdy[SF], 1);
    beat(1, 0, 0, 64'h0000_0007, 8'h20, 3'd1);
    beat(0, 1, 0, 64'h7777, 8'h00, 3'd0);
    chk("post_dv", dv[SF], 1);
    chk("post_dat", odat[SF], 64'h7);
    chk("post_memrd", mrd[SF], 1);
    chk("post_len", len[SF], 7);
    chk("post_bar", bar[SF], 8'h20);
    chk("post_func", fn[SF], 1);
    idle();
    chk("post_b1_dat", odat[SF], 64'h7777);
    chk("post_b1_eop", eop[SF], 1);
    idle();
    chk("post_done_cnt", s_pcnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/tlp_lookahead_buffer.md
# tlp_lookahead_buffer

Parametrised TLP receive buffer between the PCIe hard-IP Avalon-ST RX port and the TLP dispatchers. It decodes each packet's header on entry, queues the beats plus a per-packet descriptor, and presents the descriptor (type, length, BAR, function) before the first beat leaves. It offers cut-through or store-and-forward mode. In store-and-forward mode it discards errored or overflowing packets with write-pointer rollback.

## Interface
- pWIDTH, 64: data width; must be ≥ 32.
- pDEPTH, 64: data FIFO depth in beats; power of 2.
- pPKTS, 8: descriptor FIFO depth; power of 2.
- pSTORE_FWD, 1: 1 = release a packet only after its EOP is written; 0 = cut-through.
- pDROP_ERR, 1: store-and-forward only; discard packets with any beat carrying err.
- pREADY_MARGIN, 4: free beats required to hold o_InRxReady high.

Ports:
- i_Clk  in  1  clock
- i_ARstN  in  1  asynchronous active-low reset
- i_InRxDv, i_InRxSop, i_InRxEop, i_InRxErr, i_InRxEmpty  in  1 each  input beat qualifiers
- iv_InRxData  in  pWIDTH  input beat data; on the SOP beat, bits [31:0] carry header DW0
- i8_BarHit  in  8  BAR hit, sampled on the SOP beat
- i3_Function  in  3  function hit, sampled on the SOP beat
- o_InRxReady  out  1  registered input ready
- o_OutRxDv, o_OutRxSop, o_OutRxEop, o_OutRxErr, o_OutRxEmpty  out  1 each  output beat qualifiers
- ov_OutRxData  out  pWIDTH  output beat data
- i_OutRxReady  in  1  sink read request
- o_NxtPktValid  out  1  descriptor of the head packet is valid
- o_NxtPktMemWr, o_NxtPktMemRd, o_NxtPktIOWr, o_NxtPktIORd, o_NxtPktCmplD, o_NxtPktCmpl, o_NxtPktOthers  out  1 each  head-packet type flags
- o10_NxtPktPayldLen  out  10  head-packet length field
- o8_NxtPktBarHit  out  8  head-packet BAR hit
- o3_NxtPktFuncHit  out  3  head-packet function hit
- ov_PktCnt  out  log2(pPKTS)+1  number of complete packets queued
- o_DropPulse  out  1  one-cycle pulse per discarded packet
- o_OvfPulse  out  1  one-cycle pulse on a write attempted while the data FIFO is full

## Operation

Header decode (SOP beat):
- fmt = data[30:29], type = data[28:24], len = data[9:0].
- MemWr/MemRd: type 00000 with fmt[1] = 1 / 0.
- IOWr/IORd: type 00010 with fmt[1] = 1 / 0.
- CmplD/Cmpl: type 01010 with fmt[1] = 1 / 0.
- Others: none of the above.
- All flags and len are gated by o_NxtPktValid.

Write side:
- Every i_InRxDv beat is written (show-ahead FIFO) with {empty, err, sop, eop, data}.
- The write pointer (wptr) advances per beat. The committed pointer (cptr) marks the end of the last released beat.
- Cut-through: cptr follows wptr. The descriptor is pushed on the SOP beat.
- Store-and-forward, accept: on the EOP beat with no error, cptr ← wptr+1 and the descriptor is pushed.
- Store-and-forward, drop on error: if pDROP_ERR and an error was seen (any beat of the packet, EOP included), wptr ← cptr, no descriptor is pushed, and o_DropPulse fires.
- Full mid-packet (store-and-forward): wptr ← cptr, the remaining beats are discarded through EOP, and o_DropPulse and o_OvfPulse fire.
- SOP while a packet is open (store-and-forward): the open packet is dropped (o_DropPulse) and the new packet starts from cptr.
- Write while full (cut-through): the beat is lost and o_OvfPulse fires.

Ready:
- o_InRxReady is registered.
- It is 1 when (pDEPTH − (wptr − rptr)) > pREADY_MARGIN and the descriptor FIFO holds < pPKTS−1 entries.

Read side:
- A beat is readable while rptr ≠ cptr.
- o_OutRxDv = readable & i_OutRxReady; rptr advances on o_OutRxDv.
- The head descriptor is popped on the output EOP beat with o_OutRxDv.
- ov_PktCnt increments on the descriptor push and decrements on the pop. A simultaneous push and pop leaves it unchanged.

## Timing
- Reset (i_ARstN = 0): all pointers, counters, pulses and o_InRxReady are 0.
- After reset: all descriptor outputs and o_OutRxDv are 0. o_InRxReady goes to 1 on the first clock edge after reset release.
- Cut-through latency: a beat written at edge N is presented at output in cycle N+1. The descriptor is valid in the same cycle.
- Store-and-forward latency: EOP written at edge N; the SOP beat and descriptor are valid in cycle N+1.
- Pointers are log2(pDEPTH)+1 bits and wrap modulo 2·pDEPTH. full = (wptr − rptr) == pDEPTH.
- A single-beat packet (sop & eop) is both pushed and committed on one edge.
- Simultaneous write and read when full: the write is lost; the read proceeds.

## Test plan
- Cut-through, 3-beat MemWr (DW0 = 0x4000_0004), BAR 0x01, function 2 → o_NxtPktMemWr = 1, len = 4, BarHit = 0x01, FuncHit = 2 one cycle after SOP; beats emerge in order; ov_PktCnt returns to 0.
- Store-and-forward, 4-beat CmplD, i_OutRxReady held high → nothing is output until the cycle after EOP; then 4 consecutive beats follow.
- Store-and-forward with pDROP_ERR = 1: err set on beat 2 of 3, then a clean MemRd packet → one o_DropPulse; only the MemRd appears; ov_PktCnt peaks at 1.
- pDEPTH = 16, 20-beat store-and-forward packet, sink stalled → o_InRxReady drops when free space reaches 4; on overflow o_OvfPulse and o_DropPulse fire; the FIFO occupancy (wptr − rptr) returns to its pre-packet value.
- Fill with pPKTS−1 single-beat packets → o_InRxReady = 0; pop one → o_InRxReady = 1 one cycle later; pointer wrap over 3·pDEPTH beats produces no data corruption.
- Assert i_ARstN low mid-packet → all outputs read 0 immediately; after release, a new packet passes cleanly.
